// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants used by the fetch unit and its testbench.
package riscv_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned INSTR_W      = 32;
    localparam int unsigned FETCH_STRIDE = 4;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush and occupancy count; DEPTH must be a power of 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited PC stream to imem, in-order response buffering, redirect
// flush with drop counting of stale in-flight responses.
module fetch_unit #(
    parameter int unsigned     XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(riscv_pkg::RESET_PC),
    parameter int unsigned     IBUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    import riscv_pkg::*;

    localparam int unsigned CW = $clog2(IBUF_DEPTH) + 1;
    localparam int unsigned EW = XLEN + INSTR_W;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_d;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   w_drop_cnt_d;
    logic [CW-1:0]   w_pend_count;
    logic [CW-1:0]   w_ibuf_count;
    logic [CW+1:0]   w_inflight;
    logic [XLEN-1:0] w_pend_pc;
    logic [EW-1:0]   w_ibuf_head;
    logic            w_req_fire;
    logic            w_resp_accept;
    logic            w_ibuf_nonempty;
    logic            w_out_fire;

    // Stale responses still count against credit until they have drained.
    assign w_inflight = (CW+2)'(w_pend_count) + (CW+2)'(r_drop_cnt) + (CW+2)'(w_ibuf_count);

    assign imem_req_valid = rst_n && !redirect_valid && (w_inflight < (CW+2)'(IBUF_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_resp_accept  = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0);

    assign w_ibuf_nonempty = (w_ibuf_count != '0);
    assign out_valid       = w_ibuf_nonempty && !redirect_valid;
    assign out_pc          = w_ibuf_nonempty ? w_ibuf_head[EW-1 -: XLEN] : '0;
    assign out_instr       = w_ibuf_nonempty ? w_ibuf_head[INSTR_W-1:0] : '0;
    assign w_out_fire      = out_valid && out_ready;

    always_comb begin
        w_pc_d       = r_pc;
        w_drop_cnt_d = r_drop_cnt;
        if (redirect_valid) begin
            w_pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            // A response landing with the redirect is discarded, so it leaves the count.
            w_drop_cnt_d = w_pend_count + r_drop_cnt - CW'(imem_resp_valid);
        end else begin
            if (w_req_fire) w_pc_d = r_pc + XLEN'(FETCH_STRIDE);
            if (imem_resp_valid && (r_drop_cnt != '0)) w_drop_cnt_d = r_drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_pc       <= w_pc_d;
            r_drop_cnt <= w_drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (IBUF_DEPTH)
    ) u_pend_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_fire),
        .i_pop   (w_resp_accept),
        .i_flush (redirect_valid),
        .i_wdata (r_pc),
        .o_rdata (w_pend_pc),
        .o_count (w_pend_count)
    );

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_resp_accept),
        .i_pop   (w_out_fire),
        .i_flush (redirect_valid),
        .i_wdata ({w_pend_pc, imem_resp_data}),
        .o_rdata (w_ibuf_head),
        .o_count (w_ibuf_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reset-PC-0 instance plus a high-reset-PC twin sharing one
// in-order memory responder whose data is the first instance's address XOR a key.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic        imem_req_valid, out_valid;
    logic [31:0] imem_req_addr, out_instr, out_pc;
    logic        req_valid2, out_valid2;
    logic [31:0] req_addr2, out_instr2, out_pc2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int req_cnt = 0;
    int hs_cnt = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    logic        pv, pr;
    logic [31:0] pa;
    logic [31:0] exp_a [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] exp_h [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    logic [31:0] exp_d [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_hi (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (req_valid2),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (req_addr2),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid2),
        .out_ready       (out_ready),
        .out_instr       (out_instr2),
        .out_pc          (out_pc2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; the responder then acts on the settled request.
    task automatic step(input logic rst, input logic rdy, input logic ordy, input logic redir,
                        input logic [31:0] rpc);
        @(negedge clk);
        rst_n          = rst;
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else begin
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = q_addr[0] ^ KEY;
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                q_addr.push_back(imem_req_addr);
                q_due.push_back(cyc + lat);
                req_cnt++;
            end
            if (out_valid && out_ready) hs_cnt++;
        end
        cyc++;
    endtask

    task automatic restart(input int l);
        lat = l;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        req_cnt = 0;
        hs_cnt  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=no finish expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        out_ready       = 1'b1;

        // Reset values
        restart(1);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_req_addr_hi", req_addr2, 32'hFFFF_FFF8);

        // Streaming, 1-cycle memory, decode always ready
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("a_first_req_valid", imem_req_valid, 1);
        chk("a_first_req_addr", imem_req_addr, 32'h0);
        chk("a_first_req_addr_hi", req_addr2, 32'hFFFF_FFF8);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("a_s1_req_addr", imem_req_addr, 32'h4);
        chk("a_s1_out_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("a_out_valid", out_valid, 1);
            chk("a_out_pc", out_pc, exp_a[i]);
            chk("a_out_instr", out_instr, exp_a[i] ^ KEY);
            chk("a_out_pc_hi", out_pc2, exp_h[i]);
        end

        // Decode stalled: credits cap requests at IBUF_DEPTH
        restart(1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            if (i >= 2) chk("b_out_pc_hold", out_pc, 32'h0);
        end
        chk("b_req_count", req_cnt, 4);
        chk("b_req_valid_low", imem_req_valid, 0);
        chk("b_req_addr", imem_req_addr, 32'h10);
        chk("b_out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("b_drain_pc", out_pc, exp_d[i]);
        end

        // Redirect with three responses in flight (4-cycle memory)
        restart(4);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        chk("c_redir_req_valid", imem_req_valid, 0);
        chk("c_redir_out_valid", out_valid, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("c_req_addr", imem_req_addr, 32'h100);
        chk("c_req_valid", imem_req_valid, 1);
        chk("c_drop_out_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("c_drop_out_valid", out_valid, 0);
        end
        chk("c_credit_full", imem_req_valid, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("c_first_out_valid", out_valid, 1);
        chk("c_first_out_pc", out_pc, 32'h100);
        chk("c_first_out_instr", out_instr, 32'h1357_9ADF);

        // Redirect coincident with a response and a pending out handshake
        restart(1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        chk("d_redir_out_valid", out_valid, 0);
        chk("d_redir_req_valid", imem_req_valid, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("d_empty_out_valid", out_valid, 0);
        chk("d_req_addr", imem_req_addr, 32'h200);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("d_no_bypass", out_valid, 0);
        chk("d_handshakes", hs_cnt, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("d_out_valid", out_valid, 1);
        chk("d_out_pc", out_pc, 32'h200);
        chk("d_out_instr", out_instr, 32'h1357_99DF);

        // Random request stalls, then reset mid-stream
        restart(2);
        for (int i = 0; i < 12; i++) begin
            pv = imem_req_valid;
            pr = imem_req_ready;
            pa = imem_req_addr;
            step(1'b1, (i % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b1, 1'b0, 32'h0);
            if (pv && !pr) chk("e_addr_hold", imem_req_addr, pa);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("e_rst_req_valid", imem_req_valid, 0);
        chk("e_rst_out_valid", out_valid, 0);
        chk("e_rst_out_pc", out_pc, 0);
        chk("e_rst_out_instr", out_instr, 0);
        chk("e_rst_req_addr", imem_req_addr, 32'h0);
        chk("e_rst_req_addr_hi", req_addr2, 32'hFFFF_FFF8);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("e_first_req_valid", imem_req_valid, 1);
        chk("e_first_req_addr", imem_req_addr, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("e_no_stale_out", out_valid, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("e_out_valid", out_valid, 1);
        chk("e_out_pc", out_pc, 32'h0);
        chk("e_out_instr", out_instr, KEY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
